// File: rtl/waveform_readback_reader.sv
// AXI4 read master that streams a circular acquisition window out of DDR.
// Reading starts at startIndex and wraps at ACQ_CAPACITY. Each returned beat
// goes into a first-word-fall-through FIFO that feeds a valid/ready stream.
// At most one burst is outstanding at any time.
//
// Ports:
//   clk, reset          sole clock; asynchronous active-high reset
//   start, abort        one-cycle control pulses from the CSR logic
//   acqBase             window base byte address (only the high bits are used)
//   startIndex          first word index, sampled on start
//   wordCount           number of words to read, sampled on start
//   busy, done          run in progress; one-cycle pulse when busy falls
//   rrespErr            first non-zero RRESP of the run (sticky)
//   axi_AR* / axi_R*    AXI4 read address and read data channels
//   outData/outValid/outReady   output word stream (FIFO head)
module waveform_readback_reader #(
    parameter string       HIGH_BANDWIDTH_MODE = "FALSE",
    parameter int unsigned AXI_ADDR_WIDTH      = 32,
    parameter int unsigned AXI_DATA_WIDTH      = 128,
    parameter int unsigned FIFO_CAPACITY       = 256,
    parameter int unsigned ACQ_CAPACITY        = 1 << 23
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [AXI_ADDR_WIDTH-1:0]            acqBase,
    input  logic [$clog2(ACQ_CAPACITY)-1:0]      startIndex,
    input  logic [$clog2(ACQ_CAPACITY+1)-1:0]    wordCount,
    output logic                                 busy,
    output logic                                 done,
    output logic [1:0]                           rrespErr,
    output logic [AXI_ADDR_WIDTH-1:0]            axi_ARADDR,
    output logic [7:0]                           axi_ARLEN,
    output logic [2:0]                           axi_ARSIZE,
    output logic                                 axi_ARVALID,
    input  logic                                 axi_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]            axi_RDATA,
    input  logic [1:0]                           axi_RRESP,
    input  logic                                 axi_RLAST,
    input  logic                                 axi_RVALID,
    output logic                                 axi_RREADY,
    output logic [AXI_DATA_WIDTH-1:0]            outData,
    output logic                                 outValid,
    input  logic                                 outReady
);

    localparam int unsigned IDX_W    = $clog2(ACQ_CAPACITY);
    localparam int unsigned CNT_W    = $clog2(ACQ_CAPACITY + 1);
    localparam int unsigned BYTE_W   = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned BASE_LSB = IDX_W + BYTE_W;
    localparam int unsigned BURST    = (HIGH_BANDWIDTH_MODE == "TRUE") ? 64 : 8;
    localparam int unsigned PTR_W    = $clog2(FIFO_CAPACITY);
    localparam int unsigned FC_W     = $clog2(FIFO_CAPACITY + 1);

    // A full burst fits when the FIFO holds at most FIFO_CAPACITY-BURST words.
    localparam logic [FC_W-1:0]  FULL_FIT_LIMIT  = FC_W'(FIFO_CAPACITY - BURST);
    localparam logic [FC_W-1:0]  FIFO_FULL       = FC_W'(FIFO_CAPACITY);
    // Highest start index from which a full burst does not cross the wrap point.
    localparam logic [IDX_W:0]   LAST_FULL_START = (IDX_W + 1)'(ACQ_CAPACITY - BURST);

    if (HIGH_BANDWIDTH_MODE != "TRUE" && HIGH_BANDWIDTH_MODE != "FALSE") begin : g_bad_mode
        $error("HIGH_BANDWIDTH_MODE must be TRUE or FALSE");
    end
    if ((FIFO_CAPACITY & (FIFO_CAPACITY - 1)) != 0 || FIFO_CAPACITY < 2 * BURST) begin : g_bad_fifo
        $error("FIFO_CAPACITY must be a power of 2 and at least twice the burst length");
    end
    if ((ACQ_CAPACITY & (ACQ_CAPACITY - 1)) != 0) begin : g_bad_acq
        $error("ACQ_CAPACITY must be a power of 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t                               state;
    logic [IDX_W-1:0]                     read_index;
    logic [CNT_W-1:0]                     left;
    logic [AXI_ADDR_WIDTH-BASE_LSB-1:0]   base_hi;
    logic                                 abort_pend;

    logic [AXI_DATA_WIDTH-1:0]            mem [FIFO_CAPACITY];
    logic [PTR_W-1:0]                     wr_ptr;
    logic [PTR_W-1:0]                     rd_ptr;
    logic [FC_W-1:0]                      fifo_count;

    logic wr_en_c;
    logic rd_en_c;
    logic full_ok_c;
    logic unused_base_c;

    assign unused_base_c = ^acqBase[BASE_LSB-1:0];

    assign axi_ARADDR = {base_hi, read_index, BYTE_W'(0)};
    assign axi_ARSIZE = 3'(BYTE_W);

    assign wr_en_c   = axi_RREADY && axi_RVALID;
    assign rd_en_c   = (fifo_count != '0) && outReady;
    assign outValid  = (fifo_count != '0);
    assign outData   = mem[rd_ptr];

    assign full_ok_c = (left >= CNT_W'(BURST))
                    && ({1'b0, read_index} <= LAST_FULL_START)
                    && (fifo_count <= FULL_FIT_LIMIT);

    // FIFO storage; not reset, because occupancy is tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= axi_RDATA;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en_c) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en_c, rd_en_c})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Readback control FSM; all control outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            read_index  <= '0;
            left        <= '0;
            base_hi     <= '0;
            abort_pend  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rrespErr    <= 2'b00;
            axi_ARLEN   <= 8'd0;
            axi_ARVALID <= 1'b0;
            axi_RREADY  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                abort_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        read_index <= startIndex;
                        left       <= wordCount;
                        base_hi    <= acqBase[AXI_ADDR_WIDTH-1:BASE_LSB];
                        rrespErr   <= 2'b00;
                        abort_pend <= 1'b0;
                        if (wordCount == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    if (!axi_ARVALID) begin
                        // Nothing is committed yet, so an abort can stop here.
                        if (abort_pend || abort) begin
                            state <= S_DRAIN;
                        end else if (full_ok_c) begin
                            axi_ARLEN   <= 8'(BURST - 1);
                            axi_ARVALID <= 1'b1;
                        end else if (fifo_count != FIFO_FULL) begin
                            axi_ARLEN   <= 8'd0;
                            axi_ARVALID <= 1'b1;
                        end
                    end else if (axi_ARREADY) begin
                        axi_ARVALID <= 1'b0;
                        axi_RREADY  <= 1'b1;
                        state       <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (axi_RVALID) begin
                        read_index <= read_index + 1'b1;
                        if (left != '0) left <= left - 1'b1;
                        if (axi_RRESP != 2'b00 && rrespErr == 2'b00) begin
                            rrespErr <= axi_RRESP;
                        end
                        // RLAST ends the burst even if the beat count disagrees with ARLEN.
                        if (axi_RLAST) begin
                            axi_RREADY <= 1'b0;
                            if (left <= CNT_W'(1) || axi_RRESP != 2'b00 || rrespErr != 2'b00
                                || abort_pend || abort) begin
                                state <= S_DRAIN;
                            end else begin
                                state <= S_ADDR;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    if (fifo_count == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
